// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver with ASCII hex-digit decoder.
// Ports: clk, rst_n, RxD in; RxD_data_ready, RxD_data[7:0], RxD_frame_error,
//   hex_output[3:0], hex_error out. ASCII2HEX_LOWERCASE_EN adds 'a'-'f'.
module uart_hex_rx #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 57600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       RxD_frame_error,
  output logic [3:0] hex_output,
  output logic       hex_error
);

  localparam int CPB  = (ClkFrequency + Baud / 2) / Baud;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  localparam logic [CW-1:0] LD_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] LD_BIT  = CW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  assign rxs = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync            <= 2'b11;
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      shreg           <= '0;
      RxD_data        <= '0;
      RxD_data_ready  <= 1'b0;
      RxD_frame_error <= 1'b0;
    end else begin
      sync            <= {sync[0], RxD};
      RxD_data_ready  <= 1'b0;
      RxD_frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= LD_HALF;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rxs) begin
            cnt   <= LD_BIT;
            idx   <= '0;
            state <= DATA;
          end else begin
            // start bit vanished by mid-bit: a glitch
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= LD_BIT;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 1'b1;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            RxD_data       <= shreg;
            RxD_data_ready <= 1'b1;
            state          <= IDLE;
          end else begin
            RxD_frame_error <= 1'b1;
            state           <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // a break yields one error, not a stream of frames
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic is_dig;
  logic is_up;
  logic is_lo;

  assign is_dig = (RxD_data >= 8'h30) && (RxD_data <= 8'h39);
  assign is_up  = (RxD_data >= 8'h41) && (RxD_data <= 8'h46);
`ifdef ASCII2HEX_LOWERCASE_EN
  assign is_lo  = (RxD_data >= 8'h61) && (RxD_data <= 8'h66);
`else
  assign is_lo  = 1'b0;
`endif

  always_comb begin
    hex_output = 4'h0;
    hex_error  = 1'b1;
    unique case (1'b1)
      is_dig: begin
        hex_output = 4'(RxD_data - 8'h30);
        hex_error  = 1'b0;
      end
      is_up: begin
        hex_output = 4'(RxD_data - 8'h37);
        hex_error  = 1'b0;
      end
      is_lo: begin
        hex_output = 4'(RxD_data - 8'h57);
        hex_error  = 1'b0;
      end
      default: begin
        hex_output = 4'h0;
        hex_error  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_hex_rx.sv
// tb_uart_hex_rx: randomized bench for uart_hex_rx at CPB=16, HALF=8.
// Pulses are logged by a monitor and checked by scenario tasks.
module tb_uart_hex_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RxD;
  logic       RxD_data_ready;
  logic [7:0] RxD_data;
  logic       RxD_frame_error;
  logic [3:0] hex_output;
  logic       hex_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int both = 0;
  logic [7:0] last_good = 8'h00;

  int         r_cyc[$];
  logic [7:0] r_data[$];
  logic [3:0] r_hex[$];
  logic       r_herr[$];
  int         f_cyc[$];

  uart_hex_rx #(
    .ClkFrequency(1000000),
    .Baud(62500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RxD(RxD),
    .RxD_data_ready(RxD_data_ready),
    .RxD_data(RxD_data),
    .RxD_frame_error(RxD_frame_error),
    .hex_output(hex_output),
    .hex_error(hex_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RxD_data_ready) begin
      r_cyc.push_back(cyc);
      r_data.push_back(RxD_data);
      r_hex.push_back(hex_output);
      r_herr.push_back(hex_error);
    end
    if (RxD_frame_error) f_cyc.push_back(cyc);
    if (RxD_data_ready && RxD_frame_error) both++;
  end

  // reference: position of the byte in the hex alphabet
  function automatic logic [4:0] model(input logic [7:0] b);
    string up;
    string lo;
    up = "0123456789ABCDEF";
    lo = "abcdef";
    for (int i = 0; i < 16; i++)
      if (b == up[i]) return {1'b0, 4'(i)};
`ifdef ASCII2HEX_LOWERCASE_EN
    for (int i = 0; i < 6; i++)
      if (b == lo[i]) return {1'b0, 4'(10 + i)};
`endif
    return 5'b10000;
  endfunction

  task automatic clear_q();
    r_cyc.delete();
    r_data.delete();
    r_hex.delete();
    r_herr.delete();
    f_cyc.delete();
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic hold();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // caller is aligned #1 after a posedge; returns likewise
  task automatic send(input logic [7:0] b, input logic stp,
                      output int k);
    k = cyc;
    RxD = 1'b0;
    hold();
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      hold();
    end
    RxD = stp;
    hold();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (RxD_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", RxD_data);
    end
    checks++;
    if (RxD_data_ready !== 1'b0 || RxD_frame_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b%b want 00",
               RxD_data_ready, RxD_frame_error);
    end
    checks++;
    if (hex_output !== 4'h0 || hex_error !== 1'b1) begin
      errors++;
      $display("FAIL reset_hex got %h/%b want 0/1",
               hex_output, hex_error);
    end
    align();
    rst_n = 1'b1;
    repeat (4) align();
  endtask

  task automatic test_byte(input logic [7:0] b, input string nm);
    int k;
    logic [4:0] e;
    clear_q();
    align();
    send(b, 1'b1, k);
    repeat (4) align();
    e = model(b);
    last_good = b;
    checks++;
    if (r_cyc.size() != 1 || f_cyc.size() != 0) begin
      errors++;
      $display("FAIL %s_count got %0d rdy %0d err want 1 0",
               nm, r_cyc.size(), f_cyc.size());
      return;
    end
    checks++;
    if (r_data[0] !== b) begin
      errors++;
      $display("FAIL %s_data got %h want %h", nm, r_data[0], b);
    end
    checks++;
    if (r_hex[0] !== e[3:0] || r_herr[0] !== e[4]) begin
      errors++;
      $display("FAIL %s_hex got %h/%b want %h/%b",
               nm, r_hex[0], r_herr[0], e[3:0], e[4]);
    end
    checks++;
    if (r_cyc[0] - k < LAT - 1 || r_cyc[0] - k > LAT + 1) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d+-1",
               nm, r_cyc[0] - k, LAT);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    string pool;
    pool = "0123456789ABCDEFabcdef\r\n";
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(1, 0) == 1) b = pool[$urandom_range(24, 0)];
      else b = 8'($urandom_range(255, 0));
      test_byte(b, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v[3];
    int k[3];
    logic [4:0] e;
    v[0] = 8'h46;
    v[1] = 8'h0A;
    v[2] = 8'h30;
    clear_q();
    align();
    for (int i = 0; i < 3; i++) send(v[i], 1'b1, k[i]);
    repeat (4) align();
    last_good = v[2];
    checks++;
    if (r_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", r_cyc.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
      e = model(v[i]);
      checks++;
      if (r_data[i] !== v[i] || r_hex[i] !== e[3:0] ||
          r_herr[i] !== e[4]) begin
        errors++;
        $display("FAIL b2b_byte%0d got %h %h/%b want %h %h/%b", i,
                 r_data[i], r_hex[i], r_herr[i], v[i], e[3:0], e[4]);
      end
      if (i > 0) begin
        checks++;
        if (r_cyc[i] - r_cyc[i-1] != 10 * CPB) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want %0d", i,
                   r_cyc[i] - r_cyc[i-1], 10 * CPB);
        end
      end
    end
  endtask

  task automatic test_frame_error();
    int k;
    clear_q();
    align();
    send(8'h41, 1'b0, k);
    repeat (400) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (2 * CPB) align();
    checks++;
    if (f_cyc.size() != 1 || r_cyc.size() != 0) begin
      errors++;
      $display("FAIL ferr_count got %0d err %0d rdy want 1 0",
               f_cyc.size(), r_cyc.size());
    end else begin
      checks++;
      if (f_cyc[0] - k < LAT - 1 || f_cyc[0] - k > LAT + 1) begin
        errors++;
        $display("FAIL ferr_latency got %0d want %0d+-1",
                 f_cyc[0] - k, LAT);
      end
    end
    checks++;
    if (RxD_data !== last_good) begin
      errors++;
      $display("FAIL ferr_hold got %h want %h", RxD_data, last_good);
    end
    test_byte(8'h31, "after_break");
  endtask

  task automatic test_glitch();
    clear_q();
    align();
    RxD = 1'b0;
    repeat (3) align();
    RxD = 1'b1;
    repeat (10) align();
    checks++;
    if (r_cyc.size() != 0 || f_cyc.size() != 0) begin
      errors++;
      $display("FAIL glitch_pulses got %0d rdy %0d err want 0 0",
               r_cyc.size(), f_cyc.size());
    end
    test_byte(8'h35, "after_glitch");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'hA5;
    clear_q();
    align();
    RxD = 1'b0;
    hold();
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      hold();
    end
    RxD = b[4];
    repeat (HALF) align();
    rst_n = 1'b0;
    RxD = 1'b1;
    repeat (3) align();
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (3) align();
    checks++;
    if (RxD_data !== 8'h00 || hex_output !== 4'h0 ||
        hex_error !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs got %h %h/%b want 00 0/1",
               RxD_data, hex_output, hex_error);
    end
    repeat (12 * CPB) align();
    checks++;
    if (r_cyc.size() != 0 || f_cyc.size() != 0) begin
      errors++;
      $display("FAIL abort_pulses got %0d rdy %0d err want 0 0",
               r_cyc.size(), f_cyc.size());
    end
    test_byte(8'h39, "after_abort");
  endtask

  initial begin
    test_reset();
    test_byte(8'h37, "single");
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_byte(8'h62, "lower_b");
    test_random();
    test_reset_midframe();
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL overlap got %0d want 0", both);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
